// File: rtl/stopwatch_control.sv
// Stopwatch user control: synchronises and debounces the start/stop and lap/reset
// buttons, detects a long lap/reset press and sequences run_en/clear/hold.
module stopwatch_control #(
  parameter int DEBOUNCE_CYCLES   = 1000000,
  parameter int LONG_PRESS_CYCLES = 200000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start_stop,
  input  logic       btn_lap_reset,
  input  logic       at_max,
  output logic       run_en,
  output logic       clear,
  output logic       hold,
  output logic [1:0] state
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int LP_W = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [LP_W-1:0] LP_MAX  = LP_W'(LONG_PRESS_CYCLES);
  localparam logic [LP_W-1:0] LP_LAST = LP_W'(LONG_PRESS_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } state_t;

  // Bit 0 = start/stop, bit 1 = lap/reset.
  logic [1:0]      raw;
  logic [1:0]      sync1, sync2, level, level_d, press;
  logic [DB_W-1:0] db_cnt [2];
  logic [LP_W-1:0] lp_cnt;
  logic            long_press;
  state_t          cur, nxt;
  logic            clr_nxt;

  assign raw = {btn_lap_reset, btn_start_stop};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1   <= '0;
      sync2   <= '0;
      level   <= '0;
      level_d <= '0;
      for (int unsigned i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      level_d <= level;
      for (int unsigned i = 0; i < 2; i++) begin
        if (sync2[i] != level[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            level[i]  <= sync2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + DB_W'(1);
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  assign press = level & ~level_d;

  // Saturates at LONG_PRESS_CYCLES so a held button yields a single pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lp_cnt <= '0;
    end else if (!level[1]) begin
      lp_cnt <= '0;
    end else if (lp_cnt != LP_MAX) begin
      lp_cnt <= lp_cnt + LP_W'(1);
    end
  end

  assign long_press = level[1] && (lp_cnt == LP_LAST);

  always_comb begin
    nxt     = cur;
    clr_nxt = 1'b0;
    if (long_press) begin
      nxt     = IDLE;
      clr_nxt = 1'b1;
    end else if (press[0]) begin
      case (cur)
        IDLE, PAUSE: nxt = RUN;
        default:     nxt = PAUSE;
      endcase
    end else if (press[1]) begin
      case (cur)
        RUN:   nxt = LAP;
        LAP:   nxt = RUN;
        PAUSE: begin
          nxt     = IDLE;
          clr_nxt = 1'b1;
        end
        default: nxt = cur;
      endcase
    end else if (at_max && (cur == RUN || cur == LAP)) begin
      nxt = PAUSE;
    end
  end

  // Outputs are decoded from the next state so they change together with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur    <= IDLE;
      run_en <= 1'b0;
      hold   <= 1'b0;
      clear  <= 1'b0;
    end else begin
      cur    <= nxt;
      run_en <= (nxt == RUN) || (nxt == LAP);
      hold   <= (nxt == LAP);
      clear  <= clr_nxt;
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_stopwatch_control.sv
// Bench for stopwatch_control: directed scenarios plus random button activity,
// checked every cycle against a history-window reference model.
module tb_stopwatch_control;

  localparam int DB   = 4;
  localparam int LP   = 20;
  localparam int MAXC = 60000;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_LAP = 3;

  logic       clk = 1'b0;
  logic       reset, btn_start_stop, btn_lap_reset, at_max;
  logic       run_en, clear, hold;
  logic [1:0] state;

  stopwatch_control #(
    .DEBOUNCE_CYCLES(DB),
    .LONG_PRESS_CYCLES(LP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_start_stop(btn_start_stop),
    .btn_lap_reset(btn_lap_reset),
    .at_max(at_max),
    .run_en(run_en),
    .clear(clear),
    .hold(hold),
    .state(state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: raw samples per edge, edge index n since reset release.
  bit hist[2][MAXC];
  int n;
  bit m_db[2];
  bit m_rose[2];
  int m_lap_rise;
  int m_st;
  bit m_run, m_hold, m_clr;

  bit prev_clear;
  int last_state, moves, clear_count, run_cycles;

  function automatic bit hsamp(input int b, input int idx);
    return (idx < 0) ? 1'b0 : hist[b][idx];
  endfunction

  task automatic model_reset();
    n = 0;
    m_db[0] = 0; m_db[1] = 0;
    m_rose[0] = 0; m_rose[1] = 0;
    m_lap_rise = -1;
    m_st = M_IDLE;
    m_run = 0; m_hold = 0; m_clr = 0;
    prev_clear = 0;
    last_state = 0;
  endtask

  task automatic model_edge();
    bit sp, lpr, lg, all_diff, cl;
    int nx;
    if (n >= MAXC) begin
      $display("FAIL model_overflow: got %0d expected below %0d", n, MAXC);
      $fatal(1);
    end
    hist[0][n] = btn_start_stop;
    hist[1][n] = btn_lap_reset;
    sp  = m_rose[0];
    lpr = m_rose[1];
    lg  = m_db[1] && (m_lap_rise >= 0) && (n - m_lap_rise == LP);
    nx = m_st;
    cl = 0;
    if (lg) begin
      nx = M_IDLE; cl = 1;
    end else if (sp) begin
      nx = (m_st == M_IDLE || m_st == M_PAUSE) ? M_RUN : M_PAUSE;
    end else if (lpr) begin
      if (m_st == M_RUN) nx = M_LAP;
      else if (m_st == M_LAP) nx = M_RUN;
      else if (m_st == M_PAUSE) begin nx = M_IDLE; cl = 1; end
    end else if (at_max && (m_st == M_RUN || m_st == M_LAP)) begin
      nx = M_PAUSE;
    end
    m_st   = nx;
    m_clr  = cl;
    m_run  = (nx == M_RUN) || (nx == M_LAP);
    m_hold = (nx == M_LAP);
    // A level flips once the last DB synchronised samples all disagree with it.
    for (int b = 0; b < 2; b++) begin
      m_rose[b] = 0;
      all_diff = 1;
      for (int k = 0; k < DB; k++)
        if (hsamp(b, n - 2 - k) == m_db[b]) all_diff = 0;
      if (all_diff) begin
        m_db[b] = !m_db[b];
        if (m_db[b]) begin
          m_rose[b] = 1;
          if (b == 1) m_lap_rise = n;
        end
      end
    end
    n++;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("state", int'(state), m_st);
    check("run_en", int'(run_en), int'(m_run));
    check("hold", int'(hold), int'(m_hold));
    check("clear", int'(clear), int'(m_clr));
    check("clear_single", int'(clear & prev_clear), 0);
    prev_clear = clear;
    if (int'(state) != last_state) moves++;
    last_state = int'(state);
    if (clear) clear_count++;
    if (state == 2'd1) run_cycles++;
  endtask

  task automatic idle(input int c);
    for (int i = 0; i < c; i++) step();
  endtask

  task automatic set_btn(input int b, input bit v);
    if (b == 0) btn_start_stop = v;
    else btn_lap_reset = v;
  endtask

  task automatic press(input int b, input int c);
    set_btn(b, 1'b1);
    idle(c);
    set_btn(b, 1'b0);
    idle(8);
  endtask

  task automatic async_reset();
    #2;
    reset = 1'b1;
    #1;
    check("arst_state", int'(state), 0);
    check("arst_run_en", int'(run_en), 0);
    check("arst_hold", int'(hold), 0);
    check("arst_clear", int'(clear), 0);
    btn_start_stop = 1'b0;
    btn_lap_reset  = 1'b0;
    at_max         = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    int lat, first_clr;
    reset = 1'b1;
    btn_start_stop = 1'b0;
    btn_lap_reset  = 1'b0;
    at_max         = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", int'(state), 0);
    check("rst_run_en", int'(run_en), 0);
    check("rst_hold", int'(hold), 0);
    check("rst_clear", int'(clear), 0);
    reset = 1'b0;
    model_reset();

    // Start press latency: sync + debounce + register.
    lat = -1;
    btn_start_stop = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (lat < 0 && state == 2'd1) lat = i;
    end
    btn_start_stop = 1'b0;
    idle(8);
    check("start_latency", lat, 7);

    // Back to IDLE, then a bouncing start press must act once.
    press(0, 6);
    press(1, 6);
    moves = 0;
    for (int k = 0; k < 4; k++) begin
      btn_start_stop = (k % 2 == 0);
      idle(2);
    end
    btn_start_stop = 1'b1;
    idle(8);
    btn_start_stop = 1'b0;
    idle(8);
    check("bounce_moves", moves, 1);

    // Lap view in and out, pause, then lap clears once.
    clear_count = 0;
    press(1, 6);
    check("lap_hold", int'(hold), 1);
    press(1, 6);
    press(0, 6);
    press(1, 6);
    check("lap_clear_pulses", clear_count, 1);
    check("lap_idle", int'(state), 0);

    // Saturation at 59:59, restart with at_max still high.
    press(0, 6);
    at_max = 1'b1;
    idle(2);
    check("at_max_pause", int'(state), 2);
    run_cycles = 0;
    press(0, 6);
    check("at_max_run_cycles", run_cycles, 1);
    at_max = 1'b0;

    // Long press from RUN: LAP after debounce, clear 20 cycles after the debounced rise.
    press(0, 6);
    clear_count = 0;
    first_clr = -1;
    btn_lap_reset = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (i == 7) check("long_lap_state", int'(state), 3);
      if (first_clr < 0 && clear) first_clr = i;
    end
    btn_lap_reset = 1'b0;
    idle(10);
    check("long_clear_at", first_clr, 26);
    check("long_clear_pulses", clear_count, 1);

    // Simultaneous presses in RUN: start wins.
    press(0, 6);
    btn_start_stop = 1'b1;
    btn_lap_reset  = 1'b1;
    idle(6);
    btn_start_stop = 1'b0;
    btn_lap_reset  = 1'b0;
    idle(8);
    check("both_state", int'(state), 2);
    check("both_hold", int'(hold), 0);

    // Asynchronous reset while in LAP.
    press(0, 6);
    press(1, 6);
    check("pre_rst_lap", int'(state), 3);
    async_reset();

    for (int it = 0; it < 300; it++) begin
      case ($urandom_range(0, 6))
        0: press(0, int'($urandom_range(1, 10)));
        1: press(1, int'($urandom_range(1, 30)));
        2: begin
          for (int k = 0; k < int'($urandom_range(1, 4)); k++) begin
            btn_start_stop = 1'($urandom_range(0, 1));
            btn_lap_reset  = 1'($urandom_range(0, 1));
            idle(int'($urandom_range(1, 5)));
          end
          btn_start_stop = 1'b0;
          btn_lap_reset  = 1'b0;
        end
        3: begin
          at_max = 1'b1;
          idle(int'($urandom_range(1, 4)));
          at_max = 1'b0;
        end
        4: begin
          btn_start_stop = 1'b1;
          btn_lap_reset  = 1'b1;
          idle(int'($urandom_range(1, 10)));
          btn_start_stop = 1'b0;
          btn_lap_reset  = 1'b0;
        end
        5: idle(int'($urandom_range(1, 5)));
        default: if ($urandom_range(0, 3) == 0) async_reset();
      endcase
      idle(int'($urandom_range(0, 10)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
